// File: rtl/frogger_game_fsm_pkg.sv
// Shared Frogger game-flow definitions: state encodings, tile codes and playfield constants.
package frogger_game_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DYING     = 3'd2,
    ST_SCORED    = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    TILE_WALL  = 2'd0,
    TILE_ROAD  = 2'd1,
    TILE_WATER = 2'd2,
    TILE_GOAL  = 2'd3
  } tile_e;

  localparam int COORD_W_DEF = 6;
  localparam int GAME_W      = 40;
  localparam int GAME_H      = 30;
  localparam int START_X     = 20;
  localparam int START_Y     = 29;

endpackage

// File: rtl/frogger_game_fsm_collide.sv
// NUM_CARS-way tile comparator: flags any car sharing the frog's tile.
module frogger_game_fsm_collide #(
  parameter int NUM_CARS = 10,
  parameter int COORD_W  = 6
) (
  input  logic [COORD_W-1:0]          frog_x_i,
  input  logic [COORD_W-1:0]          frog_y_i,
  input  logic [NUM_CARS*COORD_W-1:0] car_x_i,
  input  logic [NUM_CARS*COORD_W-1:0] car_y_i,
  output logic                        hit_any_o
);

  always_comb begin
    hit_any_o = 1'b0;
    for (int k = 0; k < NUM_CARS; k++) begin
      if ((car_x_i[k*COORD_W +: COORD_W] == frog_x_i) &&
          (car_y_i[k*COORD_W +: COORD_W] == frog_y_i))
        hit_any_o = 1'b1;
    end
  end

endmodule

// File: rtl/frogger_game_fsm.sv
// Frogger game-flow controller: lives, score, level and the
// IDLE/PLAY/DYING/SCORED/GAME_OVER sequencing, all outputs registered.
module frogger_game_fsm
  import frogger_game_fsm_pkg::*;
#(
  parameter int NUM_CARS       = 10,
  parameter int COORD_W        = COORD_W_DEF,
  parameter int SCORE_W        = 7,
  parameter int SCORE_MAX      = 99,
  parameter int NUM_LIVES      = 3,
  parameter int MAX_LEVEL      = 7,
  parameter int LEVEL_UP_SCORE = 5,
  parameter int GOAL_ROW       = 0,
  parameter int DEATH_FRAMES   = 60,
  parameter int SCORE_FRAMES   = 30
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic                        i_Frame_Tick,
  input  logic                        i_Game_Start,
  input  logic [COORD_W-1:0]          i_Frogger_X,
  input  logic [COORD_W-1:0]          i_Frogger_Y,
  input  logic [NUM_CARS*COORD_W-1:0] i_Car_X,
  input  logic [NUM_CARS*COORD_W-1:0] i_Car_Y,
  input  logic                        i_Tile_Hazard,
  output logic [2:0]                  o_State,
  output logic [2:0]                  o_Lives,
  output logic [SCORE_W-1:0]          o_Score,
  output logic [2:0]                  o_Level,
  output logic                        o_Move_Enable,
  output logic                        o_Frog_Reset,
  output logic                        o_Collided
);

  localparam int CNT_MAX = (DEATH_FRAMES > SCORE_FRAMES) ? DEATH_FRAMES : SCORE_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(SCORE_MAX)) ? s : s + SCORE_W'(1);
  endfunction

  state_e             state_q;
  logic [2:0]         lives_q;
  logic [2:0]         level_q;
  logic [SCORE_W-1:0] score_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               move_en_q;
  logic               frog_rst_q;
  logic               collided_q;

  logic               car_hit;
  logic               hit_d;
  logic [SCORE_W-1:0] score_d;
  logic [2:0]         level_d;
  logic               cnt_done_d;

  frogger_game_fsm_collide #(
    .NUM_CARS (NUM_CARS),
    .COORD_W  (COORD_W)
  ) u_collide (
    .frog_x_i  (i_Frogger_X),
    .frog_y_i  (i_Frogger_Y),
    .car_x_i   (i_Car_X),
    .car_y_i   (i_Car_Y),
    .hit_any_o (car_hit)
  );

  assign hit_d   = car_hit | i_Tile_Hazard;
  assign score_d = sat_score(score_q);
  // Level bumps on every new score that is a nonzero multiple of LEVEL_UP_SCORE.
  assign level_d = ((score_d != '0) && ((score_d % SCORE_W'(LEVEL_UP_SCORE)) == '0) &&
                    (level_q < 3'(MAX_LEVEL))) ? level_q + 3'd1 : level_q;
  assign cnt_done_d = (state_q == ST_DYING) ? (cnt_q == CNT_W'(DEATH_FRAMES - 1))
                                            : (cnt_q == CNT_W'(SCORE_FRAMES - 1));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      lives_q    <= 3'd0;
      level_q    <= 3'd1;
      score_q    <= '0;
      cnt_q      <= '0;
      move_en_q  <= 1'b0;
      frog_rst_q <= 1'b0;
      collided_q <= 1'b0;
    end else begin
      frog_rst_q <= 1'b0;
      collided_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          if (i_Game_Start) begin
            state_q    <= ST_PLAY;
            lives_q    <= 3'(NUM_LIVES);
            score_q    <= '0;
            level_q    <= 3'd1;
            cnt_q      <= '0;
            frog_rst_q <= 1'b1;
            move_en_q  <= 1'b1;
          end
        end
        ST_PLAY: begin
          // A hit outranks a goal crossing in the same cycle.
          if (hit_d) begin
            state_q    <= ST_DYING;
            lives_q    <= lives_q - 3'd1;
            collided_q <= 1'b1;
            cnt_q      <= '0;
            move_en_q  <= 1'b0;
          end else if (i_Frogger_Y == COORD_W'(GOAL_ROW)) begin
            state_q   <= ST_SCORED;
            score_q   <= score_d;
            level_q   <= level_d;
            cnt_q     <= '0;
            move_en_q <= 1'b0;
          end
        end
        ST_DYING, ST_SCORED: begin
          if (i_Frame_Tick) begin
            if (cnt_done_d) begin
              cnt_q      <= '0;
              frog_rst_q <= 1'b1;
              if ((state_q == ST_DYING) && (lives_q == 3'd0)) begin
                state_q <= ST_GAME_OVER;
              end else begin
                state_q   <= ST_PLAY;
                move_en_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          move_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_State       = state_q;
  assign o_Lives       = lives_q;
  assign o_Score       = score_q;
  assign o_Level       = level_q;
  assign o_Move_Enable = move_en_q;
  assign o_Frog_Reset  = frog_rst_q;
  assign o_Collided    = collided_q;

endmodule
